// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - rv32i instruction-fetch front end with PC, imem handshake and instruction FIFO
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0060,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_address,
   output logic        imem_read,
   input  logic        imem_resp,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_ir,
   output logic [31:0] out_pc
);

   localparam int          PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int          CW  = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {FETCH, DISCARD} state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q;
   logic [31:0]     old_addr_q;
   logic            run_q;
   logic [31:0]     ir_mem [BUF_DEPTH];
   logic [31:0]     pc_mem [BUF_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            push, pop, squash_inflight;

   assign out_valid = (count_q != '0);

   // Head registers only; nothing here is combinational from imem_rdata.
   always_comb begin
      out_ir = NOP;
      out_pc = 32'h0;
      if (out_valid) begin
         out_ir = ir_mem[rd_ptr_q];
         out_pc = pc_mem[rd_ptr_q];
      end
   end

   // Read request, push/pop decisions and next state. Counting only the FIFO is enough
   // for the space test: an in-flight read keeps imem_read high, so it holds its slot.
   always_comb begin
      state_d         = state_q;
      imem_read       = 1'b0;
      imem_address    = pc_q;
      push            = 1'b0;
      squash_inflight = 1'b0;
      pop             = out_valid & out_ready & ~redirect;
      case (state_q)
         FETCH: begin
            imem_read = run_q & (count_q < CW'(BUF_DEPTH));
            if (redirect) begin
               if (imem_read & ~imem_resp) begin
                  squash_inflight = 1'b1;
                  state_d         = DISCARD;
               end
            end else begin
               push = imem_read & imem_resp;
            end
         end
         DISCARD: begin
            // The squashed read is never withdrawn; its old address stays on the bus.
            imem_read    = 1'b1;
            imem_address = old_addr_q;
            if (imem_resp) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // PC, FSM state, squashed-read address hold and the post-reset run flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         pc_q       <= {RESET_PC[31:2], 2'b00};
         old_addr_q <= 32'h0;
         run_q      <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         state_q <= state_d;
         if (redirect)
            pc_q <= {redirect_pc[31:2], 2'b00};
         else if (push)
            pc_q <= pc_q + 32'd4;
         if (squash_inflight)
            old_addr_q <= pc_q;
      end
   end

   // FIFO pointers and occupancy; redirect empties the buffer outright.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (redirect) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage; contents are qualified by count_q so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         ir_mem[wr_ptr_q] <= imem_rdata;
         pc_mem[wr_ptr_q] <= pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_address;
   logic        imem_read;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_ir;
   logic [31:0] out_pc;

   int tests = 0;
   int fails = 0;

   // scoreboard and memory model state
   logic [63:0] sb[$];
   logic [31:0] reads[$];
   logic        pending;
   logic        squashed;
   logic [31:0] pend_addr;
   logic [31:0] exp_pc;
   int          wait_cnt;
   int          lat;
   logic        hold;
   logic        ready_v;
   logic        redir_next;
   logic        redir_on_resp;
   logic [31:0] rp_v;

   fetch_stage #(.RESET_PC(32'h0000_0060), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_address(imem_address), .imem_read(imem_read),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ir(out_ir), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0013;
   endfunction

   task automatic model_reset();
      sb.delete();
      reads.delete();
      pending       = 1'b0;
      squashed      = 1'b0;
      pend_addr     = 32'h0;
      exp_pc        = 32'h0000_0060;
      wait_cnt      = 0;
      hold          = 1'b0;
      redir_next    = 1'b0;
      redir_on_resp = 1'b0;
      imem_resp     = 1'b0;
      imem_rdata    = 32'h0;
      redirect      = 1'b0;
      redirect_pc   = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // One cycle: sample at negedge, check against the model, drive inputs, advance.
   task automatic step();
      logic        resp_now;
      logic        redir;
      logic        pop;
      logic [63:0] head;
      tests++;
      if (out_valid !== (sb.size() != 0)) begin
         $display("FAIL out_valid: got %b want %b", out_valid, sb.size() != 0);
         fails++;
      end
      if (sb.size() != 0) begin
         head = sb[0];
         tests++;
         if (out_pc !== head[63:32] || out_ir !== head[31:0]) begin
            $display("FAIL head: got pc=%h ir=%h want pc=%h ir=%h", out_pc, out_ir, head[63:32], head[31:0]);
            fails++;
         end
      end else begin
         tests++;
         if (out_pc !== 32'h0 || out_ir !== 32'h0000_0013) begin
            $display("FAIL empty_head: got pc=%h ir=%h want pc=0 ir=00000013", out_pc, out_ir);
            fails++;
         end
      end
      tests++;
      if (imem_read !== (pending || sb.size() < DEPTH)) begin
         $display("FAIL imem_read: got %b want %b", imem_read, pending || sb.size() < DEPTH);
         fails++;
      end
      resp_now = 1'b0;
      if (imem_read === 1'b1) begin
         if (!pending) begin
            pending   = 1'b1;
            squashed  = 1'b0;
            pend_addr = imem_address;
            wait_cnt  = 0;
            reads.push_back(imem_address);
            tests++;
            if (imem_address !== exp_pc) begin
               $display("FAIL read_addr: got %h want %h", imem_address, exp_pc);
               fails++;
            end
         end else begin
            wait_cnt++;
            tests++;
            if (imem_address !== pend_addr) begin
               $display("FAIL addr_stable: got %h want %h", imem_address, pend_addr);
               fails++;
            end
         end
         if (!hold && wait_cnt >= lat) resp_now = 1'b1;
      end
      redir = redir_next;
      if (redir_on_resp && resp_now) begin
         redir         = 1'b1;
         redir_on_resp = 1'b0;
      end
      pop = ready_v && (sb.size() != 0) && !redir;
      imem_resp   = resp_now;
      imem_rdata  = resp_now ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      redirect    = redir;
      redirect_pc = rp_v;
      out_ready   = ready_v;
      if (redir) begin
         sb.delete();
         if (pending && !resp_now) squashed = 1'b1;
         exp_pc = {rp_v[31:2], 2'b00};
      end else begin
         if (pop) void'(sb.pop_front());
         if (resp_now && !squashed) begin
            sb.push_back({pend_addr, mem_word(pend_addr)});
            exp_pc = pend_addr + 32'd4;
         end
      end
      if (resp_now) begin
         pending  = 1'b0;
         squashed = 1'b0;
      end
      redir_next = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      out_ready = 1'b0;
      ready_v = 1'b0;
      lat = 0;
      #1;
      tests++;
      if (imem_read !== 1'b0 || out_valid !== 1'b0 || out_ir !== 32'h13 || out_pc !== 32'h0) begin
         $display("FAIL reset_outputs: got read=%b valid=%b ir=%h pc=%h want 0 0 00000013 0",
                  imem_read, out_valid, out_ir, out_pc);
         fails++;
      end
   endtask

   task automatic test_stream();
      do_reset();
      lat = 2;
      ready_v = 1'b1;
      for (int i = 0; i < 40 && reads.size() < 3; i++) step();
      repeat (4) step();
      tests++;
      if (reads.size() < 3) begin
         $display("FAIL stream_timeout: got %0d reads want 3", reads.size());
         fails++;
      end else if (reads[0] !== 32'h60 || reads[1] !== 32'h64 || reads[2] !== 32'h68) begin
         $display("FAIL stream_addrs: got %h %h %h want 00000060 00000064 00000068",
                  reads[0], reads[1], reads[2]);
         fails++;
      end
   endtask

   task automatic test_full();
      do_reset();
      lat = 0;
      ready_v = 1'b0;
      repeat (8) step();
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h60 || imem_read !== 1'b0 || reads.size() != DEPTH) begin
         $display("FAIL full_hold: got valid=%b pc=%h read=%b reads=%0d want 1 00000060 0 %0d",
                  out_valid, out_pc, imem_read, reads.size(), DEPTH);
         fails++;
      end
      ready_v = 1'b1;
      step();
      ready_v = 1'b0;
      tests++;
      if (imem_read !== 1'b1 || imem_address !== 32'h68 || out_pc !== 32'h64) begin
         $display("FAIL full_refill: got read=%b addr=%h pc=%h want 1 00000068 00000064",
                  imem_read, imem_address, out_pc);
         fails++;
      end
      repeat (3) step();
   endtask

   task automatic test_redirect_pending();
      do_reset();
      lat = 0;
      ready_v = 1'b1;
      step();
      step();
      hold = 1'b1;
      step();
      tests++;
      if (imem_read !== 1'b1 || imem_address !== 32'h68) begin
         $display("FAIL pend_setup: got read=%b addr=%h want 1 00000068", imem_read, imem_address);
         fails++;
      end
      rp_v = 32'h200;
      redir_next = 1'b1;
      step();
      tests++;
      if (imem_read !== 1'b1 || imem_address !== 32'h68 || out_valid !== 1'b0) begin
         $display("FAIL discard_hold: got read=%b addr=%h valid=%b want 1 00000068 0",
                  imem_read, imem_address, out_valid);
         fails++;
      end
      step();
      hold = 1'b0;
      step();
      step();
      tests++;
      if (reads[$] !== 32'h200) begin
         $display("FAIL discard_next: got %h want 00000200", reads[$]);
         fails++;
      end
      repeat (6) step();
   endtask

   task automatic test_redirect_resp();
      do_reset();
      lat = 1;
      ready_v = 1'b1;
      rp_v = 32'h300;
      redir_on_resp = 1'b1;
      for (int i = 0; i < 20 && redir_on_resp; i++) step();
      tests++;
      if (redir_on_resp) begin
         $display("FAIL redir_resp_timeout: got no resp want resp within 20 cycles");
         fails++;
      end else if (out_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 32'h300) begin
         $display("FAIL redir_resp: got valid=%b read=%b addr=%h want 0 1 00000300",
                  out_valid, imem_read, imem_address);
         fails++;
      end
      repeat (5) step();
   endtask

   task automatic test_align_wrap();
      int n0;
      do_reset();
      lat = 1;
      ready_v = 1'b1;
      rp_v = 32'h203;
      redir_next = 1'b1;
      step();
      n0 = reads.size();
      for (int i = 0; i < 20 && reads.size() <= n0; i++) step();
      tests++;
      if (reads.size() <= n0) begin
         $display("FAIL align_timeout: got no read want read at 00000200");
         fails++;
      end else if (reads[n0] !== 32'h200) begin
         $display("FAIL align: got %h want 00000200", reads[n0]);
         fails++;
      end
      rp_v = 32'hFFFF_FFFF;
      redir_next = 1'b1;
      step();
      n0 = reads.size();
      for (int i = 0; i < 30 && reads.size() <= n0 + 1; i++) step();
      tests++;
      if (reads.size() <= n0 + 1) begin
         $display("FAIL wrap_timeout: got %0d new reads want 2", reads.size() - n0);
         fails++;
      end else if (reads[n0] !== 32'hFFFF_FFFC || reads[n0+1] !== 32'h0) begin
         $display("FAIL wrap: got %h %h want fffffffc 00000000", reads[n0], reads[n0+1]);
         fails++;
      end
      repeat (4) step();
   endtask

   task automatic test_async_reset();
      do_reset();
      lat = 0;
      ready_v = 1'b1;
      step();
      hold = 1'b1;
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      tests++;
      if (imem_read !== 1'b0 || out_valid !== 1'b0 || out_ir !== 32'h13 || out_pc !== 32'h0) begin
         $display("FAIL async_reset: got read=%b valid=%b ir=%h pc=%h want 0 0 00000013 0",
                  imem_read, out_valid, out_ir, out_pc);
         fails++;
      end
      model_reset();
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (imem_read !== 1'b1 || imem_address !== 32'h60) begin
         $display("FAIL async_restart: got read=%b addr=%h want 1 00000060", imem_read, imem_address);
         fails++;
      end
      repeat (4) step();
   endtask

   initial begin
      ready_v = 1'b0;
      rp_v    = 32'h0;
      lat     = 0;
      test_reset();
      test_stream();
      test_full();
      test_redirect_pending();
      test_redirect_resp();
      test_align_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      fails++;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
